// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared port typedefs, FIFO output-stage states and pointer-width helper.
package jpeg_pkg;
  typedef logic [9:0] dataPort_t;
  typedef logic signed [11:0] dctPort_t;
  typedef logic [15:0] codePort_t;
  typedef enum logic [1:0] {IDLE, FETCH, VALID} out_state_t;
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  localparam int FIFO_PTR_W = fifo_ptr_w(8);
endpackage

// File: rtl/fifoRd_if.sv
// fifoRd_if: read-side handshake of the FWFT FIFO.
interface fifoRd_if #(parameter int DW = 10);
  logic en;
  logic [DW-1:0] data;
  logic empty;
  modport syncTx(input en, output data, empty);
  modport syncRx(output en, input data, empty);
endinterface

// File: rtl/fifoWr_if.sv
// fifoWr_if: write-side handshake of the FWFT FIFO.
interface fifoWr_if #(parameter int DW = 10);
  logic en;
  logic [DW-1:0] data;
  logic full;
  modport syncRx(input en, data, output full);
  modport syncTx(output en, data, input full);
endinterface

// File: rtl/ramRd_if.sv
// ramRd_if: RAM synchronous read port.
interface ramRd_if #(parameter int DW = 10, parameter int AW = 3);
  logic en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  modport Tx(input en, addr, output data);
  modport Rx(output en, addr, input data);
endinterface

// File: rtl/ramWr_if.sv
// ramWr_if: RAM write port.
interface ramWr_if #(parameter int DW = 10, parameter int AW = 3);
  logic en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  modport Tx(output en, addr, data);
  modport Rx(input en, addr, data);
endinterface

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM with registered read data.
module sdp_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH = 8
) (
  input logic clk,
  ramWr_if.Rx wr,
  ramRd_if.Tx rd
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
    if (rd.en) rd.data <= mem[rd.addr];
  end
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO built from a sync-read RAM plus an output register.
module sync_fifo_fwft
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = fifo_ptr_w(DEPTH);
  localparam int LW = AW + 1;
  fifoWr_if #(.DW(DATA_WIDTH)) wr_bus ();
  fifoRd_if #(.DW(DATA_WIDTH)) rd_bus ();
  ramWr_if #(.DW(DATA_WIDTH), .AW(AW)) ram_wr ();
  ramRd_if #(.DW(DATA_WIDTH), .AW(AW)) ram_rd ();
  out_state_t state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] ram_cnt, level_nxt;
  logic [DATA_WIDTH-1:0] rd_q;
  logic full_r, wr_acc, pop, ram_ne, fetch;
  assign wr_bus.en = wr_en;
  assign wr_bus.data = wr_data;
  assign wr_bus.full = full_r;
  assign full = wr_bus.full;
  assign rd_bus.en = rd_en;
  assign rd_bus.data = rd_q;
  assign rd_bus.empty = (state != VALID);
  assign rd_data = rd_bus.data;
  assign empty = rd_bus.empty;
  assign wr_acc = wr_bus.en & ~full_r;
  assign pop = rd_bus.en & ~rd_bus.empty;
  assign ram_ne = (ram_cnt != '0);
  // a RAM read is issued whenever the output register is (or is about to be) free
  assign fetch = ram_ne & ((state == IDLE) | pop);
  assign level_nxt = level + LW'(wr_acc) - LW'(pop);
  assign ram_wr.en = wr_acc;
  assign ram_wr.addr = wr_ptr;
  assign ram_wr.data = wr_bus.data;
  assign ram_rd.en = fetch;
  assign ram_rd.addr = rd_ptr;
  sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .wr(ram_wr),
    .rd(ram_rd)
  );
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = ram_ne ? FETCH : IDLE;
      FETCH:   state_nxt = VALID;
      VALID:   state_nxt = pop ? (ram_ne ? FETCH : IDLE) : VALID;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_cnt <= '0;
      level <= '0;
      full_r <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      rd_q <= '0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(fetch);
      ram_cnt <= ram_cnt + LW'(wr_acc) - LW'(fetch);
      level <= level_nxt;
      full_r <= (level_nxt == LW'(DEPTH));
      overflow <= wr_bus.en & full_r;
      underflow <= rd_bus.en & rd_bus.empty;
      if (state == FETCH) rd_q <= ram_rd.data;
    end
  end
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: table-driven vectors plus scoreboarded corner-case sequences.
module tb_sync_fifo_fwft;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [9:0] wr_data = '0;
  logic [9:0] rd_data;
  logic full, empty, overflow, underflow;
  logic [3:0] level;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];
  logic [9:0] last_popped = '0;
  typedef struct {
    logic we;
    logic re;
    logic [9:0] d;
    logic [3:0] lvl;
    logic emp;
    logic ful;
    logic ovf;
    logic udf;
  } vec_t;
  vec_t tbl[14];

  sync_fifo_fwft #(.DATA_WIDTH(10), .DEPTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; a pop is scored before the edge.
  task automatic cycle(input logic we, input logic re, input logic [9:0] d);
    if (re && !empty) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'(rd_data), 32'h7fffffff);
      else begin
        last_popped = sb.pop_front();
        chk("pop_data", 32'(rd_data), 32'(last_popped));
      end
    end
    if (we && !full) sb.push_back(d);
    wr_en = we;
    rd_en = re;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (empty && n < 10) begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end
    if (empty) chk({name, "_timeout"}, 32'(empty), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 10'h011, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 10'h022, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'h033, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 10'h044, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 10'h000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 10'h000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    #2;
    chk("reset_outputs", {level, empty, full, overflow, underflow}, {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].d);
      chk($sformatf("vec%0d", i), {level, empty, full, overflow, underflow},
          {tbl[i].lvl, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].udf});
    end

    cycle(1'b1, 1'b0, 10'h2A5);
    chk("lat_k", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, '0);
    chk("lat_k1", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, '0);
    chk("lat_k2", {empty, rd_data}, {1'b0, 10'h2A5});
    cycle(1'b0, 1'b1, '0);

    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 10'(i));
    chk("fill_full", {full, level}, {1'b1, 4'd8});
    cycle(1'b1, 1'b0, 10'h3FF);
    chk("fill_ovf", {overflow, full, level}, {1'b1, 1'b1, 4'd8});
    cycle(1'b0, 1'b0, '0);
    chk("fill_ovf_pulse", 32'(overflow), 32'd0);
    wait_valid("fill");
    cycle(1'b1, 1'b1, 10'h155);
    chk("full_wr_rd", {level, overflow, full}, {4'd7, 1'b1, 1'b0});
    for (int n = 0; n < 40 && !(level == 0 && empty); n++) cycle(1'b0, 1'b1, '0);
    chk("drain_done", {level, empty}, {4'd0, 1'b1});
    chk("drain_sb", 32'(sb.size()), 32'd0);

    cycle(1'b1, 1'b0, 10'h100);
    wait_valid("wrap_prime");
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 1'b1, 10'(10'h100 + i));
      chk($sformatf("wrap_lvl%0d", i), 32'(level), 32'd1);
      wait_valid("wrap");
    end
    cycle(1'b0, 1'b1, '0);
    chk("wrap_last", 32'(last_popped), 32'h114);

    cycle(1'b0, 1'b1, '0);
    chk("udf_pulse", {underflow, level, empty, rd_data}, {1'b1, 4'd0, 1'b1, last_popped});
    cycle(1'b0, 1'b0, '0);
    chk("udf_clear", 32'(underflow), 32'd0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 10'(10'h0A1 + i));
    wait_valid("rst_fill");
    rst_n = 1'b0;
    #2;
    chk("rst_async", {empty, level, full}, {1'b1, 4'd0, 1'b0});
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 10'h0B1);
    chk("rst_first_wr", 32'(level), 32'd1);
    wait_valid("rst_after");
    cycle(1'b0, 1'b1, '0);
    chk("rst_sb", {32'(sb.size()), last_popped}, {32'd0, 10'h0B1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 Parameter DATA_WIDTH, default 10: payload width in bits.
REQ-002 Parameter DEPTH, default 8: total capacity in words; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request; sampled at the clock edge.
REQ-006 wr_data  input  DATA_WIDTH  write payload.
REQ-007 full  output  1  no free slot.
REQ-008 rd_en  input  1  pop request for the word currently presented.
REQ-009 rd_data  output  DATA_WIDTH  head word; valid whenever empty=0 (first-word-fall-through).
REQ-010 empty  output  1  no word presented on rd_data.
REQ-011 level  output  $clog2(DEPTH)+1  number of stored words, including the presented word.
REQ-012 overflow  output  1  one-cycle pulse when a write is refused.
REQ-013 underflow  output  1  one-cycle pulse when a read is refused.
REQ-014 The group wr_en/wr_data/full SHALL bind to fifoWr_if.syncRx, and the group rd_en/rd_data/empty SHALL bind to fifoRd_if.syncTx.

Function
REQ-015 A write SHALL be accepted only when wr_en=1 and full=0.
- A refused write leaves state unchanged and pulses overflow on the next cycle.
REQ-016 A read SHALL be accepted only when rd_en=1 and empty=0.
- A refused read pulses underflow on the next cycle.
REQ-017 Storage SHALL be a DEPTH-entry RAM with a synchronous read, followed by a one-word output register.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-018 The output stage SHALL be a 3-state FSM:
- IDLE: register empty.
- FETCH: RAM read issued.
- VALID: register holds the head word.
REQ-019 FSM transitions:
- IDLE->FETCH when the RAM is non-empty.
- FETCH->VALID always.
- VALID->FETCH when a pop occurs and the RAM is non-empty.
- VALID->IDLE when a pop occurs and the RAM is empty.
- VALID->VALID otherwise.
REQ-020 empty SHALL be 1 in IDLE and FETCH, and 0 in VALID.
REQ-021 Write-to-read latency into an empty FIFO: a word written at edge k SHALL appear on rd_data with empty=0 after edge k+2.
REQ-022 Back-to-back pops SHALL sustain one word every two cycles minimum; one word per cycle is permitted if a prefetch path is implemented.
- Ordering SHALL be strict FIFO in all cases.
REQ-023 level SHALL update each cycle as +1 (accepted write only), -1 (accepted read only), or unchanged (both or neither).
REQ-024 full SHALL equal (level==DEPTH), and it SHALL be registered so it is valid in the same cycle as level.
REQ-025 Simultaneous wr_en and rd_en while full=1: the read SHALL be accepted, the write SHALL be refused, and overflow SHALL pulse.
REQ-026 Simultaneous wr_en and rd_en while empty=1 and level=0: the write SHALL be accepted, the read SHALL be refused, and underflow SHALL pulse.
REQ-027 rd_data SHALL hold its value when no pop occurs, and SHALL hold its last value while empty=1.

Reset
REQ-028 While rst_n=0, the following SHALL be forced immediately, independent of clk:
- pointers=0, level=0, FSM=IDLE.
- full=0, empty=1, overflow=0, underflow=0, rd_data=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents; RAM contents need not be cleared.
REQ-030 The first accepted write SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 The dataPort_t, dctPort_t and codePort_t typedefs and the FIFO pointer-width helper constant SHALL reside in a shared package, jpeg_pkg.
REQ-032 The RAM SHALL be a separate sub-module, sdp_ram, with a ramWr_if.Rx write port and a ramRd_if.Tx read port, parameterised by DATA_WIDTH and DEPTH.

Verification
REQ-033 Reset test: assert rst_n=0 mid-stream.
- Required: empty=1, level=0, full=0 with no clock edge.
- Required: the data present before reset is never read afterwards.
REQ-034 Fill/drain test: write 0x001..0x008 with no reads.
- Required: full=1, level=8.
- A 9th write (0x3FF) is refused and overflow pulses.
- Draining returns 0x001..0x008 in order, then empty=1.
REQ-035 Latency test: write 0x2A5 at edge k into an empty FIFO.
- Required: empty=1 at k+1, then empty=0 with rd_data=0x2A5 at k+2.
REQ-036 Wrap test: perform 20 interleaved writes/reads of an incrementing value with level kept between 1 and 3.
- Required: the read sequence matches the write sequence across pointer wrap.
REQ-037 Simultaneous access at the boundaries:
- At full: wr+rd gives level 8->7, overflow=1, and the popped word is correct.
- At level=1 in VALID: wr+rd gives level stays 1, and the new word is presented.
REQ-038 Underflow test: rd_en=1 on an empty FIFO.
- Required: underflow pulses for 1 cycle, level stays 0, and rd_data is unchanged.
